// File: rtl/ahb_input_hold_stage.sv
// Per-master AHB matrix input stage: holds a denied address phase and stalls the master until granted.
// Optional `AHB_INPUT_STALL_CNT_EN adds a saturating count of stalled (pending) cycles.
module ahb_input_hold_stage #(
    parameter int AW = 32,
    parameter int MW = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSELS,
    input  logic [AW-1:0] HADDRS,
    input  logic [AW-1:0] HAUSERS,
    input  logic [1:0]    HTRANSS,
    input  logic          HWRITES,
    input  logic [2:0]    HSIZES,
    input  logic [2:0]    HBURSTS,
    input  logic [3:0]    HPROTS,
    input  logic [MW-1:0] HMASTERS,
    input  logic          HMASTLOCKS,
    input  logic          HREADYS,
    output logic          HREADYOUTS,
    output logic          HRESPS,
`ifdef AHB_INPUT_STALL_CNT_EN
    input  logic          clr_stall,
    output logic [15:0]   stall_cnt,
`endif
    output logic          sel_ip,
    output logic [AW-1:0] addr_ip,
    output logic [AW-1:0] auser_ip,
    output logic [1:0]    trans_ip,
    output logic          write_ip,
    output logic [2:0]    size_ip,
    output logic [2:0]    burst_ip,
    output logic [3:0]    prot_ip,
    output logic [MW-1:0] master_ip,
    output logic          mastlock_ip,
    output logic          held_tran_ip,
    input  logic          active_ip,
    input  logic          readyout_ip,
    input  logic          resp_ip
);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic          tran_valid;
    logic          capture;
    logic          granted;
    logic          accept;
    logic          pend_tran;
    logic          data_phase;
    logic          held_is_seq;

    logic [AW-1:0] hold_addr;
    logic [AW-1:0] hold_auser;
    logic [1:0]    hold_trans;
    logic          hold_write;
    logic [2:0]    hold_size;
    logic [2:0]    hold_burst;
    logic [3:0]    hold_prot;
    logic [MW-1:0] hold_master;
    logic          hold_mastlock;

    assign tran_valid  = HSELS & HTRANSS[1] & HREADYS;
    assign capture     = HSELS & HREADYS;
    assign granted     = active_ip & readyout_ip;
    assign held_is_seq = (hold_trans == TRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_addr     <= '0;
            hold_auser    <= '0;
            hold_trans    <= '0;
            hold_write    <= 1'b0;
            hold_size     <= '0;
            hold_burst    <= '0;
            hold_prot     <= '0;
            hold_master   <= '0;
            hold_mastlock <= 1'b0;
        end else if (capture) begin
            hold_addr     <= HADDRS;
            hold_auser    <= HAUSERS;
            hold_trans    <= HTRANSS;
            hold_write    <= HWRITES;
            hold_size     <= HSIZES;
            hold_burst    <= HBURSTS;
            hold_prot     <= HPROTS;
            hold_master   <= HMASTERS;
            hold_mastlock <= HMASTLOCKS;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran <= 1'b0;
        end else if (tran_valid && !granted) begin
            pend_tran <= 1'b1;
        end else if (pend_tran && granted) begin
            pend_tran <= 1'b0;
        end
    end

    // A held SEQ beat loses its burst context once stalled, so it is re-issued as a NONSEQ INCR.
    always_comb begin
        if (pend_tran) begin
            sel_ip      = 1'b1;
            addr_ip     = hold_addr;
            auser_ip    = hold_auser;
            trans_ip    = held_is_seq ? TRANS_NONSEQ : hold_trans;
            write_ip    = hold_write;
            size_ip     = hold_size;
            burst_ip    = held_is_seq ? BURST_INCR : hold_burst;
            prot_ip     = hold_prot;
            master_ip   = hold_master;
            mastlock_ip = hold_mastlock;
        end else begin
            sel_ip      = HSELS;
            addr_ip     = HADDRS;
            auser_ip    = HAUSERS;
            trans_ip    = HTRANSS;
            write_ip    = HWRITES;
            size_ip     = HSIZES;
            burst_ip    = HBURSTS;
            prot_ip     = HPROTS;
            master_ip   = HMASTERS;
            mastlock_ip = HMASTLOCKS;
        end
    end

    assign held_tran_ip = pend_tran | tran_valid;
    assign accept       = held_tran_ip & trans_ip[1] & granted;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_phase <= 1'b0;
        end else if (accept) begin
            data_phase <= 1'b1;
        end else if (readyout_ip) begin
            data_phase <= 1'b0;
        end
    end

    assign HREADYOUTS = data_phase ? readyout_ip : ~pend_tran;
    assign HRESPS     = data_phase ? resp_ip : 1'b0;

`ifdef AHB_INPUT_STALL_CNT_EN
    // Clearing wins over counting so software sees a clean zero even mid-stall.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt <= '0;
        end else if (clr_stall) begin
            stall_cnt <= '0;
        end else if (pend_tran && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_input_hold_stage.sv
// Bench for ahb_input_hold_stage: directed vector table, hand sequences for reset/stall counter,
// and random traffic checked against a transfer-level model.
module tb_ahb_input_hold_stage;

    localparam int AW = 32;
    localparam int MW = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b1;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [AW-1:0] HAUSERS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic [MW-1:0] HMASTERS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic          HRESPS;
`ifdef AHB_INPUT_STALL_CNT_EN
    logic          clr_stall;
    logic [15:0]   stall_cnt;
`endif
    logic          sel_ip;
    logic [AW-1:0] addr_ip;
    logic [AW-1:0] auser_ip;
    logic [1:0]    trans_ip;
    logic          write_ip;
    logic [2:0]    size_ip;
    logic [2:0]    burst_ip;
    logic [3:0]    prot_ip;
    logic [MW-1:0] master_ip;
    logic          mastlock_ip;
    logic          held_tran_ip;
    logic          active_ip;
    logic          readyout_ip;
    logic          resp_ip;

    ahb_input_hold_stage #(.AW(AW), .MW(MW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
`ifdef AHB_INPUT_STALL_CNT_EN
        .clr_stall(clr_stall), .stall_cnt(stall_cnt),
`endif
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
        .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
        .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
        .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] auser;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic [MW-1:0] master;
        logic          mastlock;
    } xfer_t;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        hready;
        logic        active;
        logic        readyout;
        logic        resp;
        logic        e_hro;
        logic        e_hresp;
        logic        e_held;
        logic [1:0]  e_trans;
        logic [2:0]  e_burst;
        logic [31:0] e_addr;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    vec_t  vecs[19];

    // Transfer-level model: at most one stalled transfer waiting, plus whether a data phase is owed.
    xfer_t pend_q[$];
    bit    m_dphase;
    int    m_stall;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                                 input logic [2:0] burst, input logic hready, input logic active,
                                 input logic readyout, input logic resp);
        HSELS       = sel;
        HADDRS      = addr;
        HAUSERS     = '0;
        HTRANSS     = trans;
        HWRITES     = 1'b1;
        HSIZES      = 3'd2;
        HBURSTS     = burst;
        HPROTS      = 4'd3;
        HMASTERS    = 4'd1;
        HMASTLOCKS  = 1'b0;
        HREADYS     = hready;
        active_ip   = active;
        readyout_ip = readyout;
        resp_ip     = resp;
    endtask

    function automatic xfer_t liveXfer();
        xfer_t x;
        x.addr = HADDRS; x.auser = HAUSERS; x.trans = HTRANSS; x.write = HWRITES;
        x.size = HSIZES; x.burst = HBURSTS; x.prot = HPROTS; x.master = HMASTERS;
        x.mastlock = HMASTLOCKS;
        return x;
    endfunction

    task automatic resetDut();
        applyStimulus(1'b0, 32'h0, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef AHB_INPUT_STALL_CNT_EN
        clr_stall = 1'b0;
`endif
        HRESETn = 1'b0;
        pend_q.delete();
        m_dphase = 1'b0;
        m_stall = 0;
        @(negedge HCLK);
        checkOutput("reset_hreadyout", 64'(HREADYOUTS), 64'(1));
        checkOutput("reset_hresp", 64'(HRESPS), 64'(0));
        checkOutput("reset_held", 64'(held_tran_ip), 64'(0));
        checkOutput("reset_trans", 64'(trans_ip), 64'(0));
`ifdef AHB_INPUT_STALL_CNT_EN
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic randomStep();
        xfer_t src;
        bit    act, ro, exp_hro, exp_sel, tv, held, accept, had_pend;
        ro  = ($urandom_range(0, 3) != 0);
        act = ($urandom_range(0, 2) != 0);
        exp_hro = m_dphase ? ro : (pend_q.size() == 0);
        HSELS       = ($urandom_range(0, 3) != 0);
        HADDRS      = $urandom;
        HAUSERS     = $urandom;
        HTRANSS     = 2'($urandom_range(0, 3));
        HWRITES     = 1'($urandom_range(0, 1));
        HSIZES      = 3'($urandom_range(0, 7));
        HBURSTS     = 3'($urandom_range(0, 7));
        HPROTS      = 4'($urandom_range(0, 15));
        HMASTERS    = 4'($urandom_range(0, 15));
        HMASTLOCKS  = 1'($urandom_range(0, 1));
        HREADYS     = exp_hro;
        active_ip   = act;
        readyout_ip = ro;
        resp_ip     = 1'($urandom_range(0, 1));
`ifdef AHB_INPUT_STALL_CNT_EN
        clr_stall   = ($urandom_range(0, 15) == 0);
`endif
        @(negedge HCLK);
        tv = HSELS && HTRANSS[1] && HREADYS;
        had_pend = (pend_q.size() != 0);
        if (had_pend) begin
            src = pend_q[0];
            if (src.trans == 2'b11) begin
                src.trans = 2'b10;
                src.burst = 3'b001;
            end
            exp_sel = 1'b1;
        end else begin
            src = liveXfer();
            exp_sel = HSELS;
        end
        held = had_pend || tv;
        checkOutput("rnd_hreadyout", 64'(HREADYOUTS), 64'(exp_hro));
        checkOutput("rnd_hresp", 64'(HRESPS), 64'(m_dphase ? resp_ip : 1'b0));
        checkOutput("rnd_held", 64'(held_tran_ip), 64'(held));
        checkOutput("rnd_sel", 64'(sel_ip), 64'(exp_sel));
        checkOutput("rnd_addr", 64'(addr_ip), 64'(src.addr));
        checkOutput("rnd_auser", 64'(auser_ip), 64'(src.auser));
        checkOutput("rnd_trans", 64'(trans_ip), 64'(src.trans));
        checkOutput("rnd_write", 64'(write_ip), 64'(src.write));
        checkOutput("rnd_size", 64'(size_ip), 64'(src.size));
        checkOutput("rnd_burst", 64'(burst_ip), 64'(src.burst));
        checkOutput("rnd_prot", 64'(prot_ip), 64'(src.prot));
        checkOutput("rnd_master", 64'(master_ip), 64'(src.master));
        checkOutput("rnd_mastlock", 64'(mastlock_ip), 64'(src.mastlock));
`ifdef AHB_INPUT_STALL_CNT_EN
        checkOutput("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (clr_stall) m_stall = 0;
        else if (had_pend && m_stall < 65535) m_stall++;
`endif
        accept = held && src.trans[1] && act && ro;
        if (had_pend && act && ro) void'(pend_q.pop_front());
        if (tv && !(act && ro)) begin
            pend_q.delete();
            pend_q.push_back(liveXfer());
        end
        if (accept) m_dphase = 1'b1;
        else if (ro) m_dphase = 1'b0;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        //           sel   addr          trans  burst   hrdy  act   rdy   resp  eHro  eResp eHeld eTrans eBurst  eAddr
        vecs[0]  = '{1'b0, 32'h0,        2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0};
        vecs[1]  = '{1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h2000_0010};
        vecs[2]  = '{1'b0, 32'h0,        2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0};
        vecs[3]  = '{1'b0, 32'h0,        2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0};
        vecs[4]  = '{1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h2000_0010};
        vecs[5]  = '{1'b1, 32'h3000_0000, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h2000_0010};
        vecs[6]  = '{1'b1, 32'h3000_0004, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h2000_0010};
        vecs[7]  = '{1'b1, 32'h3000_0008, 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h2000_0010};
        vecs[8]  = '{1'b0, 32'h3000_0000, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h3000_0000};
        vecs[9]  = '{1'b1, 32'h104,      2'b11, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 3'b011, 32'h104};
        vecs[10] = '{1'b1, 32'h108,      2'b11, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 32'h104};
        vecs[11] = '{1'b1, 32'h108,      2'b11, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 32'h104};
        vecs[12] = '{1'b1, 32'h108,      2'b11, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 3'b011, 32'h108};
        vecs[13] = '{1'b1, 32'h0,        2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0};
        vecs[14] = '{1'b0, 32'h0,        2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0};
        vecs[15] = '{1'b1, 32'h40,       2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h40};
        vecs[16] = '{1'b1, 32'h44,       2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 32'h44};
        vecs[17] = '{1'b1, 32'h48,       2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h44};
        vecs[18] = '{1'b0, 32'h0,        2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0};

        #1;
        resetDut();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].trans, vecs[i].burst,
                          vecs[i].hready, vecs[i].active, vecs[i].readyout, vecs[i].resp);
            @(negedge HCLK);
            checkOutput($sformatf("vec%0d_hreadyout", i), 64'(HREADYOUTS), 64'(vecs[i].e_hro));
            checkOutput($sformatf("vec%0d_hresp", i), 64'(HRESPS), 64'(vecs[i].e_hresp));
            checkOutput($sformatf("vec%0d_held", i), 64'(held_tran_ip), 64'(vecs[i].e_held));
            checkOutput($sformatf("vec%0d_trans", i), 64'(trans_ip), 64'(vecs[i].e_trans));
            checkOutput($sformatf("vec%0d_burst", i), 64'(burst_ip), 64'(vecs[i].e_burst));
            checkOutput($sformatf("vec%0d_addr", i), 64'(addr_ip), 64'(vecs[i].e_addr));
            @(posedge HCLK);
            #1;
        end

        // Reset pulsed while a denied transfer is pending for two cycles.
        resetDut();
        applyStimulus(1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge HCLK);
        #1;
        applyStimulus(1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("midpend_hreadyout", 64'(HREADYOUTS), 64'(0));
        HRESETn = 1'b0;
        #1;
        checkOutput("rst_pend_hreadyout", 64'(HREADYOUTS), 64'(1));
        checkOutput("rst_pend_held", 64'(held_tran_ip), 64'(0));
`ifdef AHB_INPUT_STALL_CNT_EN
        checkOutput("rst_pend_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

`ifdef AHB_INPUT_STALL_CNT_EN
        resetDut();
        applyStimulus(1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge HCLK);
        #1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 32'h2000_0010, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge HCLK);
            checkOutput($sformatf("stall_cnt_k%0d", k), 64'(stall_cnt), 64'(k - 1));
            @(posedge HCLK);
            #1;
        end
        clr_stall = 1'b1;
        @(negedge HCLK);
        checkOutput("stall_cnt_5", 64'(stall_cnt), 64'(5));
        @(posedge HCLK);
        #1;
        clr_stall = 1'b0;
        active_ip = 1'b1;
        @(negedge HCLK);
        checkOutput("stall_cnt_cleared", 64'(stall_cnt), 64'(0));
        @(posedge HCLK);
        #1;
`endif

        resetDut();
        for (int n = 0; n < 3000; n++) begin
            randomStep();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
